// File: rtl/serial_param_pkg.sv
// Shared definitions for the serial parameter receivers (weights and thresholds).
package serial_param_pkg;

  // Commit modes: shift-chain (fold==1) or addressed via word_addr.
  localparam int ADDR_MODE_SHIFT = 0;
  localparam int ADDR_MODE_INDEX = 1;

  // ceil(log2(n)) with a floor of 1 so single-entry banks still get a 1-bit address.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of word_addr / rd_addr for a bank of 'depth' words.
  function automatic int addr_w(input int depth);
    return clog2_min1(depth);
  endfunction

  // Bit counter width: must hold 0..word_w+1 (word_w+1 marks an over-length word).
  function automatic int cnt_w(input int word_w);
    return clog2_min1(word_w + 2);
  endfunction

endpackage

// File: rtl/serial_param_receiver_deser.sv
// Bit deserializer: MSB-first shift register plus a saturating bit counter.
module bit_deserializer
  import serial_param_pkg::*;
#(
  parameter int WORD_W = 576,
  parameter int CNT_W  = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,     // asynchronous, active-low
  input  logic              clear,     // synchronous, overrides shift/flush
  input  logic              shift_en,  // accept bit_in this cycle
  input  logic              flush,     // word consumed: zero sr and counter
  input  logic              bit_in,
  output logic [WORD_W-1:0] sr,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              len_ok     // exactly WORD_W bits collected
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W:0]   shifted;

  // Next state: clear wins, then flush, then shift; counter sticks at WORD_W+1.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    shifted = {sr_q, bit_in};
    if (clear || flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      sr_d = shifted[WORD_W-1:0];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr      = sr_q;
  assign bit_cnt = cnt_q;
  assign len_ok  = (cnt_q == CNT_FULL);

endmodule

// File: rtl/serial_param_receiver.sv
// Receive end of the bit-serial parameter load protocol. Deserializes words and
// commits them into a DEPTH-entry bank exposed flat and through a registered read port.
// Handshake: bit_en and word_en are valid-only strobes; the receiver is always
// ready (no back-pressure), so every strobe is consumed in the cycle it is seen.
module serial_param_receiver
  import serial_param_pkg::*;
#(
  parameter int WORD_W    = 576,
  parameter int DEPTH     = 64,
  parameter int ADDR_MODE = ADDR_MODE_SHIFT,
  parameter int ADDR_W    = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    bit_en,
  input  logic                    word_en,
  input  logic [ADDR_W-1:0]       word_addr,
  input  logic                    clear,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WORD_W-1:0]       rd_data,
  output logic [DEPTH*WORD_W-1:0] words_flat,
  output logic [ADDR_W:0]         word_count,
  output logic                    loaded,
  output logic                    err_len,
  output logic                    err_collide,
  output logic                    err_addr
);

  localparam int              CNT_W     = cnt_w(WORD_W);
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] bank_q [DEPTH];
  logic [WORD_W-1:0] bank_d [DEPTH];
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_len_q, err_len_d;
  logic              err_col_q, err_col_d;
  logic              err_addr_q, err_addr_d;

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              len_ok;

  logic commit_req;  // clean commit strobe (may still target a bad address)
  logic collide;
  logic addr_ok;
  logic commit_do;   // commit that actually writes the bank

  assign commit_req = word_en & ~bit_en & ~clear;
  assign collide    = word_en & bit_en & ~clear;
  assign addr_ok    = (ADDR_MODE == ADDR_MODE_SHIFT) || (int'(word_addr) < DEPTH);
  assign commit_do  = commit_req & addr_ok;

  bit_deserializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_deser (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (bit_en & ~word_en),
    .flush    (word_en & ~bit_en),
    .bit_in   (bit_in),
    .sr       (sr),
    .bit_cnt  (bit_cnt),
    .len_ok   (len_ok)
  );

  // The raw count is only needed by observers of the deserializer; the top uses len_ok.
  logic unused_sigs;
  assign unused_sigs = ^{bit_cnt, word_addr};

  // Bank next state: shift chain or addressed write on a performed commit.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) bank_d[k] = bank_q[k];
    if (commit_do) begin
      if (ADDR_MODE == ADDR_MODE_SHIFT) begin
        bank_d[0] = sr;
        for (int k = 1; k < DEPTH; k++) bank_d[k] = bank_q[k-1];
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (int'(word_addr) == k) bank_d[k] = sr;
        end
      end
    end
  end

  // Counter, sticky flags and read mux; clear resets counters/flags, not the bank.
  always_comb begin
    count_d    = count_q;
    err_len_d  = err_len_q | (commit_req & ~len_ok);
    err_col_d  = err_col_q | collide;
    err_addr_d = err_addr_q | (commit_req & ~addr_ok);
    if (commit_do && count_q != COUNT_MAX) count_d = count_q + 1'b1;
    if (clear) begin
      count_d    = '0;
      err_len_d  = 1'b0;
      err_col_d  = 1'b0;
      err_addr_d = 1'b0;
    end
    rd_data_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(rd_addr) == k) rd_data_d = bank_q[k];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) bank_q[k] <= '0;
      rd_data_q  <= '0;
      count_q    <= '0;
      err_len_q  <= 1'b0;
      err_col_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) bank_q[k] <= bank_d[k];
      rd_data_q  <= rd_data_d;
      count_q    <= count_d;
      err_len_q  <= err_len_d;
      err_col_q  <= err_col_d;
      err_addr_q <= err_addr_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign words_flat[k*WORD_W +: WORD_W] = bank_q[k];
  end

  assign rd_data     = rd_data_q;
  assign word_count  = count_q;
  assign loaded      = (count_q == COUNT_MAX);
  assign err_len     = err_len_q;
  assign err_collide = err_col_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_serial_param_receiver.sv
// Directed bench: u0 is a shift-chain bank (4x4), u1 an addressed bank (5x4).
module tb_serial_param_receiver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- u0: WORD_W=4, DEPTH=4, shift mode ----------------
  logic        bit_in0 = 1'b0, bit_en0 = 1'b0, word_en0 = 1'b0, clear0 = 1'b0;
  logic [1:0]  word_addr0 = '0, rd_addr0 = '0;
  logic [3:0]  rd_data0;
  logic [15:0] flat0;
  logic [2:0]  count0;
  logic        loaded0, err_len0, err_col0, err_addr0;

  serial_param_receiver #(.WORD_W(4), .DEPTH(4), .ADDR_MODE(0)) u0 (
    .clk(clk), .reset(reset), .bit_in(bit_in0), .bit_en(bit_en0), .word_en(word_en0),
    .word_addr(word_addr0), .clear(clear0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .words_flat(flat0), .word_count(count0), .loaded(loaded0), .err_len(err_len0),
    .err_collide(err_col0), .err_addr(err_addr0)
  );

  // ---------------- u1: WORD_W=4, DEPTH=5, addressed mode ----------------
  logic        bit_in1 = 1'b0, bit_en1 = 1'b0, word_en1 = 1'b0, clear1 = 1'b0;
  logic [2:0]  word_addr1 = '0, rd_addr1 = '0;
  logic [3:0]  rd_data1;
  logic [19:0] flat1;
  logic [3:0]  count1;
  logic        loaded1, err_len1, err_col1, err_addr1;

  serial_param_receiver #(.WORD_W(4), .DEPTH(5), .ADDR_MODE(1)) u1 (
    .clk(clk), .reset(reset), .bit_in(bit_in1), .bit_en(bit_en1), .word_en(word_en1),
    .word_addr(word_addr1), .clear(clear1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .words_flat(flat1), .word_count(count1), .loaded(loaded1), .err_len(err_len1),
    .err_collide(err_col1), .err_addr(err_addr1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the low n bits of value, MSB first.
  task automatic send_bits(input int which, input logic [7:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (which == 0) begin bit_en0 = 1'b1; bit_in0 = value[i]; end
      else            begin bit_en1 = 1'b1; bit_in1 = value[i]; end
      tick();
    end
    bit_en0 = 1'b0; bit_en1 = 1'b0; bit_in0 = 1'b0; bit_in1 = 1'b0;
  endtask

  task automatic commit(input int which, input logic [2:0] addr);
    if (which == 0) begin word_en0 = 1'b1; word_addr0 = addr[1:0]; end
    else            begin word_en1 = 1'b1; word_addr1 = addr; end
    tick();
    word_en0 = 1'b0; word_en1 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_flat0", flat0, 16'h0);
    check("rst_count0", count0, 3'd0);
    check("rst_loaded0", loaded0, 1'b0);
    check("rst_errs0", {err_len0, err_col0, err_addr0}, 3'b000);
    check("rst_flat1", flat1, 20'h0);
    reset = 1'b1;
    tick();

    // Test 1: shift chain, words A,5,C,3
    send_bits(0, 8'hA, 4); commit(0, 3'd0);
    send_bits(0, 8'h5, 4); commit(0, 3'd0);
    send_bits(0, 8'hC, 4); commit(0, 3'd0);
    check("t1_count3", count0, 3'd3);
    check("t1_loaded3", loaded0, 1'b0);
    send_bits(0, 8'h3, 4); commit(0, 3'd0);
    check("t1_flat", flat0, 16'hA5C3);
    check("t1_count4", count0, 3'd4);
    check("t1_loaded", loaded0, 1'b1);
    check("t1_errs", {err_len0, err_col0, err_addr0}, 3'b000);

    // Test 2: addressed mode
    send_bits(1, 8'h9, 4); commit(1, 3'd2);
    check("t2_flat_w2", flat1, 20'h00900);
    check("t2_count1", count1, 4'd1);
    send_bits(1, 8'h7, 4); commit(1, 3'd5);
    check("t2_err_addr", err_addr1, 1'b1);
    check("t2_flat_keep", flat1, 20'h00900);
    check("t2_count_keep", count1, 4'd1);
    check("t2_err_len", err_len1, 1'b0);
    rd_addr1 = 3'd2; tick();
    check("t2_rd2", rd_data1, 4'h9);
    rd_addr1 = 3'd6; tick();
    check("t2_rd_oor", rd_data1, 4'h0);
    rd_addr1 = 3'd2;
    send_bits(1, 8'h6, 4); commit(1, 3'd2);
    check("t2_rd_old", rd_data1, 4'h9);
    check("t2_flat_new", flat1, 20'h00600);
    check("t2_count2", count1, 4'd2);
    tick();
    check("t2_rd_new", rd_data1, 4'h6);

    // Test 3: short and long words
    send_bits(0, 8'h5, 3); commit(0, 3'd0);
    check("t3_short_flat", flat0, 16'h5C35);
    check("t3_short_err", err_len0, 1'b1);
    check("t3_count_sat", count0, 3'd4);
    send_bits(0, 8'b0011_0010, 6); commit(0, 3'd0);
    check("t3_long_flat", flat0, 16'hC352);
    check("t3_long_err", err_len0, 1'b1);

    // Test 4: collision drops the bit and blocks the commit
    send_bits(0, 8'b11, 2);
    bit_en0 = 1'b1; bit_in0 = 1'b0; word_en0 = 1'b1;
    tick();
    bit_en0 = 1'b0; word_en0 = 1'b0;
    check("t4_collide", err_col0, 1'b1);
    check("t4_flat_keep", flat0, 16'hC352);
    send_bits(0, 8'b01, 2); commit(0, 3'd0);
    check("t4_resume_flat", flat0, 16'h352D);

    // Test 6: clear keeps bank, zeroes counters and flags
    clear0 = 1'b1; tick(); clear0 = 1'b0;
    check("t6_errs", {err_len0, err_col0, err_addr0}, 3'b000);
    check("t6_count", count0, 3'd0);
    check("t6_loaded", loaded0, 1'b0);
    check("t6_flat", flat0, 16'h352D);
    rd_addr0 = 2'd0; tick();
    check("t6_rd0", rd_data0, 4'hD);
    rd_addr0 = 2'd3; tick();
    check("t6_rd3", rd_data0, 4'h3);

    // Test 5: asynchronous reset mid-word, then a clean word
    send_bits(0, 8'b11, 2);
    #2 reset = 1'b0;
    #1;
    check("t5_flat0", flat0, 16'h0);
    check("t5_rd0", rd_data0, 4'h0);
    check("t5_count0", count0, 3'd0);
    check("t5_flat1", flat1, 20'h0);
    check("t5_errs1", {err_len1, err_col1, err_addr1}, 3'b000);
    tick();
    reset = 1'b1;
    tick();
    send_bits(0, 8'hF, 4); commit(0, 3'd0);
    check("t5_word0", flat0, 16'h000F);
    check("t5_count", count0, 3'd1);
    check("t5_errs", {err_len0, err_col0, err_addr0}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
